tff_mod_counter: RTL and testbench

//   Synchronous modulo-N up/down counter built from a column of toggle

---
 rtl/tff_mod_counter_pkg.sv | 8 +
 rtl/tff_mod_counter_tff_cell.sv | 22 ++
 rtl/tff_mod_counter.sv | 62 ++++++
 tb/tb_tff_mod_counter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/tff_mod_counter_pkg.sv
// tff_mod_counter_pkg: shared constants for the modulo-N toggle counter
//   COUNT_UP / COUNT_DOWN : encodings of the up input
//   DEFAULT_WIDTH         : default counter width
package tff_mod_counter_pkg;
   localparam logic COUNT_UP      = 1'b1;
   localparam logic COUNT_DOWN    = 1'b0;
   localparam int   DEFAULT_WIDTH = 4;
endpackage

// File: rtl/tff_mod_counter_tff_cell.sv
// tff_cell: behavioural toggle flip-flop, async active-low reset to Q=0
//   T    in  toggle request, sampled on rising clk
//   clk  in  clock
//   nRst in  asynchronous active-low reset
//   Q    out stored bit
//   nQ   out inverse of Q
module tff_cell
   import tff_mod_counter_pkg::*;
(
   input  logic T,
   input  logic clk,
   input  logic nRst,
   output logic Q,
   output logic nQ
);
   logic q_q;
   always_ff @(posedge clk or negedge nRst)
      if (!nRst) q_q <= 1'b0;
      else if (T) q_q <= ~q_q;
   assign Q  = q_q;
   assign nQ = ~q_q;
endmodule

// File: rtl/tff_mod_counter.sv
// tff_mod_counter: modulo-N up/down counter built from a column of toggle cells
//   clk  in  clock, rising edge
//   nRst in  asynchronous active-low reset
//   en   in  count enable
//   up   in  direction (1 = up, 0 = down)
//   load in  synchronous load of d (clamped to MODULUS-1), beats en
//   d    in  load value
//   Q    out current count
//   nQ   out ~Q
//   tc   out combinational terminal count
//   wrap out registered pulse the cycle after a wrap
module tff_mod_counter
   import tff_mod_counter_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MODULUS = 2**WIDTH
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] nQ,
   output logic             tc,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
   logic [WIDTH-1:0] next_d, t, q_bits, nq_bits, load_val;
   logic             at_max, at_zero, wrap_d, wrap_q;
   assign at_max   = Q == MAX;
   assign at_zero  = Q == '0;
   // widened compare so a full power-of-two modulus never clamps
   assign load_val = ({1'b0, d} >= MOD_W) ? MAX : d;
   assign tc       = en & ((up == COUNT_UP) ? at_max : at_zero);
   always_comb begin
      next_d = load ? load_val
             : !en  ? Q
             : (up == COUNT_UP) ? (at_max ? '0 : Q + WIDTH'(1))
             : (at_zero ? MAX : Q - WIDTH'(1));
      wrap_d = !load & tc;
   end
   // every state change is expressed as a toggle of the differing bits
   assign t = Q ^ next_d;
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
         .T   (t[i]),
         .clk (clk),
         .nRst(nRst),
         .Q   (q_bits[i]),
         .nQ  (nq_bits[i])
      );
   end
   always_ff @(posedge clk or negedge nRst)
      if (!nRst) wrap_q <= 1'b0;
      else wrap_q <= wrap_d;
   assign Q    = q_bits;
   assign nQ   = nq_bits;
   assign wrap = wrap_q;
endmodule

// File: tb/tb_tff_mod_counter.sv
// tb_tff_mod_counter: directed and random checks of two counter instances
module tb_tff_mod_counter;
   logic       clk = 1'b0;
   bit         run = 1'b0;
   logic       nRst;
   logic       en4, up4, load4, en8, up8, load8;
   logic [3:0] d4, Q4, nQ4;
   logic [2:0] d8, Q8, nQ8;
   logic       tc4, wrap4, tc8, wrap8;
   int n_chk = 0, n_fail = 0;
   int m4 = 0, m8 = 0;
   bit w4 = 0, w8 = 0;
   int wraps;

   always begin
      #5;
      if (run) clk = ~clk;
   end

   tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut4 (
      .clk(clk), .nRst(nRst), .en(en4), .up(up4), .load(load4), .d(d4),
      .Q(Q4), .nQ(nQ4), .tc(tc4), .wrap(wrap4));
   tff_mod_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
      .clk(clk), .nRst(nRst), .en(en8), .up(up8), .load(load8), .d(d8),
      .Q(Q8), .nQ(nQ8), .tc(tc8), .wrap(wrap8));

   function automatic int nxt(int m, int md, bit ld, int dv, bit e, bit u);
      if (ld) return (dv >= md) ? md - 1 : dv;
      if (!e) return m;
      return u ? (m + 1) % md : (m + md - 1) % md;
   endfunction

   function automatic bit wrapped(int m, int md, bit ld, bit e, bit u);
      return !ld && e && (u ? m == md - 1 : m == 0);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      check({tag, " Q4"}, 32'(Q4), m4);
      check({tag, " nQ4"}, 32'(nQ4), m4 ^ 15);
      check({tag, " wrap4"}, 32'(wrap4), 32'(w4));
      check({tag, " tc4"}, 32'(tc4), 32'(en4 && (up4 ? m4 == 9 : m4 == 0)));
      check({tag, " Q8"}, 32'(Q8), m8);
      check({tag, " nQ8"}, 32'(nQ8), m8 ^ 7);
      check({tag, " wrap8"}, 32'(wrap8), 32'(w8));
      check({tag, " tc8"}, 32'(tc8), 32'(en8 && (up8 ? m8 == 7 : m8 == 0)));
   endtask

   // one rising edge: model advances from the inputs present at the edge
   task automatic tick(input string tag);
      int n4, n8;
      bit x4, x8;
      n4 = nxt(m4, 10, load4, int'(d4), en4, up4);
      x4 = wrapped(m4, 10, load4, en4, up4);
      n8 = nxt(m8, 8, load8, int'(d8), en8, up8);
      x8 = wrapped(m8, 8, load8, en8, up8);
      @(posedge clk);
      #1;
      m4 = n4; w4 = x4; m8 = n8; w8 = x8;
      chk_all(tag);
   endtask

   initial begin
      nRst = 1'b0;
      {en4, up4, load4, d4} = '0;
      {en8, up8, load8, d8} = '0;
      #3;
      chk_all("reset_stopped");
      #2;
      nRst = 1'b1;
      #2;
      run = 1'b1;
      en4 = 1'b1; up4 = 1'b1;
      repeat (3) tick("count3");
      check("after3", 32'(Q4), 3);

      load4 = 1'b1; d4 = 4'd8;
      tick("load8");
      load4 = 1'b0;
      tick("up9");
      check("up9_tc", 32'(tc4), 1);
      tick("upwrap");
      check("upwrap_pulse", 32'(wrap4), 1);
      tick("up1");
      check("up1_nowrap", 32'(wrap4), 0);

      load4 = 1'b1; d4 = 4'd1;
      tick("load1");
      load4 = 1'b0; up4 = 1'b0;
      tick("down0");
      check("down0_tc", 32'(tc4), 1);
      tick("downwrap");
      check("downwrap_q", 32'(Q4), 9);

      load4 = 1'b1; en4 = 1'b1; d4 = 4'd13;
      tick("clamp");
      check("clamp_q", 32'(Q4), 9);
      load4 = 1'b0; en4 = 1'b0;
      repeat (5) tick("hold");

      load4 = 1'b1; d4 = 4'd6;
      tick("load6");
      load4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
      #2;
      nRst = 1'b0;
      #1;
      m4 = 0; m8 = 0; w4 = 0; w8 = 0;
      chk_all("async_reset");
      en4 = 1'b0;
      nRst = 1'b1;

      en8 = 1'b1; up8 = 1'b1;
      wraps = 0;
      repeat (10) begin
         tick("w3_up");
         if (wrap8) wraps++;
      end
      check("w3_q", 32'(Q8), 2);
      check("w3_wraps", 32'(wraps), 1);

      repeat (300) begin
         en4 = 1'($urandom); up4 = 1'($urandom); load4 = ($urandom_range(7) == 0);
         d4 = 4'($urandom_range(15));
         en8 = 1'($urandom); up8 = 1'($urandom); load8 = ($urandom_range(7) == 0);
         d8 = 3'($urandom_range(7));
         #1;
         chk_all("rand_pre");
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
